// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access path.
//   MEM_AW / MEM_DW : default address and data widths of the shared word memory
//   RD / WR         : values of the memory R_W line
//   state_e         : states of the arbiter/sequencer FSM
package mem_pkg;

  localparam int MEM_AW = 16;
  localparam int MEM_DW = 16;

  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE  = 3'd2,
    RELEASE = 3'd3,
    ABORT   = 3'd4,
    DRAIN   = 3'd5
  } state_e;

endpackage

// File: rtl/mem_arbiter_sync2.sv
// Two-flop synchroniser for a single asynchronous level (e.g. memory MFC).
//   clk   : destination clock
//   reset : asynchronous, active-high; both flops clear to 0
//   d_i   : asynchronous input
//   q_o   : input resynchronised into clk (two-cycle latency)
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester round-robin controller for the shared word memory with an
// EN / R_W / MFC strobe handshake. Port 0 is instruction fetch, port 1 is
// load/store. One access is sequenced at a time; a missing MFC is aborted
// after TIMEOUT cycles.
//   clk, reset               : clock, asynchronous active-high reset
//   reqN/rwN/addrN/wdataN    : requester N level request and access fields
//   ackN/errN                : one-cycle completion / timeout pulses
//   rdataN                   : last read data for requester N
//   mem_addr/mem_din/mem_rw  : memory address, write data, direction (1 read)
//   mem_en                   : memory enable strobe (acts on rising edge)
//   mem_dout/mem_mfc         : memory read data and async completion pulse
//   busy                     : high whenever the sequencer is not idle
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int AW        = MEM_AW,
  parameter int DW        = MEM_DW,
  parameter int TIMEOUT   = 32,
  parameter int SETUP_CYC = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          rw0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic          err0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          rw1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic          err1,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_rw,
  output logic          mem_en,
  input  logic [DW-1:0] mem_dout,
  input  logic          mem_mfc,
  output logic          busy
);

  localparam int CMAX = (TIMEOUT > SETUP_CYC) ? TIMEOUT : SETUP_CYC;
  localparam int CW   = $clog2(CMAX + 1);

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic          rw_q, rw_d;
  logic          en_q, en_d;
  logic          ack0_q, ack0_d, ack1_q, ack1_d;
  logic          err0_q, err0_d, err1_q, err1_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic          gnt;
  logic          mfc_s;

  sync2 u_mfc_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (mem_mfc),
    .q_o   (mfc_s)
  );

  // Single requester wins outright; on a tie the port that did not win last.
  always_comb begin
    gnt = (req0 && req1) ? ~last_q : req1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      rw_q     <= RD;
      en_q     <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      rw_q     <= rw_d;
      en_q     <= en_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Outputs are registered: the ack/err pulse and the EN fall are decided on
  // the edge that enters RELEASE/ABORT, so they appear during that state.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    din_d    = din_q;
    rw_d     = rw_q;
    en_d     = en_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    err0_d   = 1'b0;
    err1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;

    case (state_q)
      IDLE: begin
        en_d = 1'b0;
        if (req0 || req1) begin
          owner_d = gnt;
          last_d  = gnt;
          addr_d  = gnt ? addr1 : addr0;
          din_d   = gnt ? wdata1 : wdata0;
          rw_d    = gnt ? rw1 : rw0;
          cnt_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == CW'(SETUP_CYC - 1)) begin
          en_d    = 1'b1;
          cnt_d   = '0;
          state_d = STROBE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STROBE: begin
        cnt_d = cnt_q + CW'(1);
        if (mfc_s) begin
          en_d = 1'b0;
          if (owner_q) ack1_d = 1'b1;
          else         ack0_d = 1'b1;
          // Read data lands in the requester's register together with ack.
          if (rw_q == RD) begin
            if (owner_q) rdata1_d = mem_dout;
            else         rdata0_d = mem_dout;
          end
          state_d = RELEASE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          en_d = 1'b0;
          if (owner_q) err1_d = 1'b1;
          else         err0_d = 1'b1;
          state_d = ABORT;
        end
      end
      RELEASE, ABORT: begin
        cnt_d   = '0;
        state_d = DRAIN;
      end
      DRAIN: begin
        // A stretched or late MFC must fall before the next access may start;
        // a stuck-high MFC is given up on after TIMEOUT cycles.
        if (!mfc_s) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(TIMEOUT - 1)) state_d = IDLE;
        end
      end
      default: begin
        en_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign err0     = err0_q;
  assign err1     = err1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign mem_addr = addr_q;
  assign mem_din  = din_q;
  assign mem_rw   = rw_q;
  assign mem_en   = en_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester controller for the shared 16-bit word memory and its EN / R_W / MFC strobe-handshake interface.
- Requester 0 is the instruction-fetch path; requester 1 is the data (load/store) path.
- Arbitrates between them round-robin and sequences one memory access at a time.
- Synchronises the asynchronous MFC (memory function complete) pulse into clk, returns read data and an acknowledge pulse, and flags a timeout if MFC never arrives.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- TIMEOUT, 32, clk cycles to wait in STROBE for synchronised MFC before aborting.
- SETUP_CYC, 1, cycles address/data/R_W are held stable before EN rises (≥1).

Ports:
- clk  in  1  system clock; period must be < 1/3 of the minimum MFC high time.
- reset  in  1  reset, asynchronous, active-high.
- req0  in  1  requester 0 access request, level, held until ack0/err0.
- rw0  in  1  requester 0 direction: 1 read, 0 write.
- addr0  in  AW  requester 0 address.
- wdata0  in  DW  requester 0 write data.
- ack0  out  1  one-cycle pulse: access complete.
- err0  out  1  one-cycle pulse: access timed out.
- rdata0  out  DW  read data, valid in the ack0 cycle and held until the next ack0.
- req1, rw1, addr1, wdata1, ack1, err1, rdata1: same as the port-0 signals, for requester 1.
- mem_addr  out  AW  memory address.
- mem_din  out  DW  memory write data.
- mem_rw  out  1  memory R_W (1 read).
- mem_en  out  1  memory enable strobe; the memory acts on its rising edge.
- mem_dout  in  DW  memory read data.
- mem_mfc  in  1  asynchronous completion pulse from the memory.
- busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Reset values (asynchronous): state=IDLE; mem_en=0; mem_rw=1; mem_addr=0; mem_din=0; ack*/err*=0; rdata*=0; busy=0; last_grant=1 (so port 0 wins the first tie); MFC synchroniser flops=0; counters=0.
- mem_mfc passes through a 2-flop synchroniser giving mfc_s. Only mfc_s is used.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the port ≠ last_grant.
  - On grant, latch addr/rw/wdata into mem_addr/mem_rw/mem_din, record the owner, set last_grant, go to SETUP.
  - mem_en stays 0.
- SETUP:
  - Count SETUP_CYC cycles, then set mem_en=1 and go to STROBE.
  - Address/data/rw are stable ≥ SETUP_CYC cycles before the EN rising edge.
- STROBE:
  - mem_en held at 1; timeout counter increments each cycle.
  - If mfc_s=1, capture mem_dout into an internal buffer when rw=1, and go to RELEASE.
  - If the counter reaches TIMEOUT first: go to ABORT.
- RELEASE:
  - mem_en=0.
  - Pulse ack of the owner for exactly one cycle.
  - For reads, update that port's rdata from the buffer in the same cycle.
  - Go to DRAIN.
- ABORT:
  - mem_en=0.
  - Pulse err of the owner for one cycle.
  - rdata is unchanged.
  - Go to DRAIN.
- DRAIN:
  - Wait until mfc_s=0 so a late or stretched MFC cannot complete the next access.
  - Then go to IDLE.
  - A DRAIN lasting more than TIMEOUT cycles also returns to IDLE (stuck-MFC guard). No pulse is emitted.
- Minimum latency, req to ack: 1 (IDLE) + SETUP_CYC + synchroniser delay (2) + 1 = 5 cycles when MFC arrives immediately.
- The requester must drop req in the cycle after ack/err, or it is re-granted. Round-robin still alternates if the other port is requesting.
- Inputs addr/rw/wdata are sampled only at grant; changes afterwards are ignored.
- mem_en is never asserted for two accesses without an intervening low ≥1 cycle, which guarantees a fresh rising edge per access.
- Reset mid-access: mem_en drops immediately (asynchronous). No ack/err is issued.
- ack0 and ack1 are never high together; at most one of ack/err is high in any cycle.

Decomposition:
- Shared package mem_pkg:
  - state encoding constants IDLE, SETUP, STROBE, RELEASE, ABORT, DRAIN;
  - default AW/DW;
  - direction constants RD=1, WR=0.
- One natural sub-module: sync2 (2-flop synchroniser with async reset), also reusable by other MFC consumers.

Test Plan:
- Single read: memory model pre-loaded mem[0]=4; req0=1, rw0=1, addr0=0 → mem_en rises after SETUP, MFC pulse, ack0 one cycle, rdata0=0x0004, busy back to 0.
- Write then read: port1 writes 0xBEEF to addr 7, then reads addr 7 → ack1 twice, rdata1=0xBEEF, err1 never set.
- Contention: req0 and req1 held high continuously, 4 accesses → grant order 0,1,0,1; each mem_en rising edge preceded by ≥1 low cycle.
- Timeout: memory model never pulses MFC, TIMEOUT=32 → err0 pulses at STROBE cycle 32, mem_en falls, no ack0, rdata0 unchanged, next request serviced normally.
- Late MFC: MFC arrives after the abort → DRAIN absorbs it; the following access still requires its own MFC (no spurious ack).
- Async reset asserted in STROBE → mem_en=0, busy=0 immediately; no ack/err; after release, a fresh req0 completes with correct data.
